// File: rtl/cond_it_unit.sv
// ARM condition check stage with NZCV register and Thumb-2 IT tracking.
// Optional FLAG_BYPASS_EN forwards same-cycle flag writes into evaluation.
module cond_it_unit #(
   parameter int unsigned IT_MAX      = 4,
   parameter bit          RESERVED_NV = 1'b0,
   parameter logic [3:0]  FLAG_RESET  = 4'h0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flag_we,
   input  logic [3:0] flag_in,
   output logic [3:0] flags,
   input  logic       inst_valid,
   input  logic [3:0] inst_cond,
   output logic       inst_ready,
   input  logic       it_start,
   input  logic [3:0] it_firstcond,
   input  logic [3:0] it_mask,
   output logic       it_active,
   output logic [2:0] it_remaining,
   output logic       it_err,
   output logic       exec_valid,
   input  logic       exec_ready,
   output logic       exec_pass,
   output logic [3:0] exec_cond,
   output logic       exec_in_it
);

   logic [7:0] itstate;
   logic       accept;
   logic [2:0] start_len;
   logic       start_ok;
   logic [3:0] applied_cond;
   logic [3:0] eval_flags;

   // Position of the lowest set mask bit gives the instructions left.
   function automatic logic [2:0] blk_len(input logic [3:0] m);
      logic [2:0] n;
      if (m[0])      n = 3'd4;
      else if (m[1]) n = 3'd3;
      else if (m[2]) n = 3'd2;
      else if (m[3]) n = 3'd1;
      else           n = 3'd0;
      return n;
   endfunction

   function automatic logic cond_pass(input logic [3:0] cc,
                                      input logic [3:0] f);
      logic n, z, c, v, r;
      {n, z, c, v} = f;
      case (cc)
         4'h0:    r = z;
         4'h1:    r = !z;
         4'h2:    r = c;
         4'h3:    r = !c;
         4'h4:    r = n;
         4'h5:    r = !n;
         4'h6:    r = v;
         4'h7:    r = !v;
         4'h8:    r = c && !z;
         4'h9:    r = !c || z;
         4'hA:    r = (n == v);
         4'hB:    r = (n != v);
         4'hC:    r = !z && (n == v);
         4'hD:    r = z || (n != v);
         4'hE:    r = 1'b1;
         default: r = !RESERVED_NV;
      endcase
      return r;
   endfunction

   assign inst_ready   = !exec_valid || exec_ready;
   assign accept       = inst_valid && inst_ready;
   assign it_active    = (itstate[3:0] != 4'h0);
   assign it_remaining = blk_len(itstate[3:0]);
   assign start_len    = blk_len(it_mask);
   assign start_ok     = !it_active && (it_mask != 4'h0) &&
                         (32'(start_len) <= IT_MAX);
   assign applied_cond = it_active ? itstate[7:4] : inst_cond;

`ifdef FLAG_BYPASS_EN
   assign eval_flags = flag_we ? flag_in : flags;
`else
   assign eval_flags = flags;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         flags      <= FLAG_RESET;
         itstate    <= 8'h00;
         it_err     <= 1'b0;
         exec_valid <= 1'b0;
         exec_pass  <= 1'b0;
         exec_cond  <= 4'h0;
         exec_in_it <= 1'b0;
      end else begin
         if (flag_we)
            flags <= flag_in;
         it_err <= it_start && !start_ok;
         if (accept) begin
            exec_valid <= 1'b1;
            exec_cond  <= applied_cond;
            exec_pass  <= cond_pass(applied_cond, eval_flags);
            exec_in_it <= it_active;
            if (it_active) begin
               if (itstate[2:0] == 3'b000)
                  itstate <= 8'h00;
               else
                  itstate[4:0] <= {itstate[3:0], 1'b0};
            end
         end else if (exec_ready) begin
            exec_valid <= 1'b0;
         end
         // A start is only accepted while idle, so it never races an advance.
         if (it_start && start_ok)
            itstate <= {it_firstcond, it_mask};
      end
   end

endmodule
